hc_mmio_rd_responder: RTL and testbench

- Responder for host MMIO reads on CCI-P: decodes c0 mmioRdValid requests and returns CSR contents on c2 MmioRdRsp.
- Read-side counterpart of the HardCloud MMIO write decoders (DSM base, control, buffer table); it also exposes DFH/AFU ID, accelerator status and a read counter.
- Sits in the AFU top beside the CSR write logic.
- Two-stage pipeline; accepts one read per cycle with no back-pressure.

---
 rtl/hc_mmio_rd_responder.sv | 180 ++++++++++++++++++
 tb/tb_hc_mmio_rd_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hc_mmio_rd_responder.sv
// hc_ccip_pkg: minimal CCI-P channel types used by the MMIO read responder,
// plus the HardCloud buffer table entry layout.
package hc_ccip_pkg;

   localparam int unsigned MMIO_ADDR_W = 16;
   localparam int unsigned MMIO_TID_W  = 9;
   localparam int unsigned MMIO_DATA_W = 64;
   localparam int unsigned CL_DATA_W   = 512;
   localparam int unsigned C0_HDR_W    = 28;

   // c0 response header; opaque here, reinterpreted as an MMIO request header
   typedef logic [C0_HDR_W-1:0] t_ccip_c0_RspMemHdr;

   typedef struct packed {
      logic [MMIO_ADDR_W-1:0] address;   // 4-byte units
      logic [1:0]             length;    // 0: 4B, 1: 8B
      logic                   rsvd;
      logic [MMIO_TID_W-1:0]  tid;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr   hdr;
      logic [CL_DATA_W-1:0] data;
      logic                 rspValid;
      logic                 mmioRdValid;
      logic                 mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      logic [MMIO_TID_W-1:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr    hdr;
      logic                   mmioRdValid;
      logic [MMIO_DATA_W-1:0] data;
   } t_if_ccip_c2_Tx;

   // Buffer table entry: address in [95:32], size in [31:0]
   typedef struct packed {
      logic [63:0] address;
      logic [31:0] size;
   } t_hc_buffer;

endpackage

// hc_mmio_rd_responder: answers host MMIO reads on CCI-P c0 with CSR
// contents on c2, two-stage pipeline, one read per cycle, no back-pressure.
// Ports:
//   clk, reset_n     CCI-P clock, async active-low reset
//   rx_c0            host c0 channel (only mmioRdValid and hdr are used)
//   tx_c2            MMIO read response (registered)
//   csr_dsm_base     DSM base register
//   csr_control      HC_CONTROL register
//   csr_buffers      packed t_hc_buffer array, entry i at [96*i +: 96]
//   status           {rd_state[2:0], wr_state[2:0], busy, done}
//   rd_count         responses issued since reset (registered, wraps)
module hc_mmio_rd_responder
   import hc_ccip_pkg::*;
#(
   parameter logic [63:0] AFU_ID_L    = 64'h0,
   parameter logic [63:0] AFU_ID_H    = 64'h0,
   parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_1000,
   parameter int unsigned BUFFER_SIZE = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  t_if_ccip_c0_Rx               rx_c0,
   output t_if_ccip_c2_Tx               tx_c2,
   input  logic [63:0]                  csr_dsm_base,
   input  logic [31:0]                  csr_control,
   input  logic [BUFFER_SIZE*96-1:0]    csr_buffers,
   input  logic [7:0]                   status,
   output logic [15:0]                  rd_count
);

   localparam int unsigned QW_IDX_W     = 7;     // 8-byte slots below byte 0x400
   localparam int unsigned BUF_W        = 96;
   localparam int unsigned BUF_BASE_IDX = 36;    // byte 0x120
   localparam int unsigned MAX_SLOTS    = 13;    // table ends before 0x1F0
   localparam int unsigned NUM_SLOTS    = (BUFFER_SIZE < MAX_SLOTS) ? BUFFER_SIZE : MAX_SLOTS;

   localparam logic [QW_IDX_W-1:0] IDX_DFH      = 7'h00;
   localparam logic [QW_IDX_W-1:0] IDX_AFU_ID_L = 7'h01;
   localparam logic [QW_IDX_W-1:0] IDX_AFU_ID_H = 7'h02;
   localparam logic [QW_IDX_W-1:0] IDX_DSM_BASE = 7'h22;
   localparam logic [QW_IDX_W-1:0] IDX_CONTROL  = 7'h23;
   localparam logic [QW_IDX_W-1:0] IDX_STATUS   = 7'h3E;
   localparam logic [QW_IDX_W-1:0] IDX_RD_COUNT = 7'h3F;

   t_ccip_c0_ReqMmioHdr    req_hdr_c;
   logic                   in_window_c;
   logic [QW_IDX_W-1:0]    qw_idx_c;
   logic [63:0]            word_c;
   logic                   is_cnt_c;

   logic                   s1_valid;
   logic [MMIO_TID_W-1:0]  s1_tid;
   logic                   s1_len8;
   logic                   s1_hi;
   logic                   s1_is_cnt;
   logic [63:0]            s1_word;

   logic [63:0]            rsp_word_c;
   logic [63:0]            rsp_data_c;

   // Request decode: select the 64-bit CSR word for the 8-byte slot
   always_comb begin
      req_hdr_c   = t_ccip_c0_ReqMmioHdr'(rx_c0.hdr);
      in_window_c = (req_hdr_c.address[MMIO_ADDR_W-1:8] == 8'h0);
      qw_idx_c    = req_hdr_c.address[7:1];
      word_c      = 64'h0;
      is_cnt_c    = 1'b0;
      if (in_window_c) begin
         case (qw_idx_c)
            IDX_DFH:      word_c = DFH_VALUE;
            IDX_AFU_ID_L: word_c = AFU_ID_L;
            IDX_AFU_ID_H: word_c = AFU_ID_H;
            IDX_DSM_BASE: word_c = csr_dsm_base;
            IDX_CONTROL:  word_c = {32'h0, csr_control};
            IDX_STATUS:   word_c = {56'h0, status};
            // resolved in stage 2 so back-to-back count reads stay exact
            IDX_RD_COUNT: is_cnt_c = 1'b1;
            default:      word_c = 64'h0;
         endcase
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (qw_idx_c == QW_IDX_W'(BUF_BASE_IDX + 2*i))
               word_c = csr_buffers[BUF_W*i+32 +: 64];
            if (qw_idx_c == QW_IDX_W'(BUF_BASE_IDX + 2*i + 1))
               word_c = {32'h0, csr_buffers[BUF_W*i +: 32]};
         end
      end
   end

   // Stage 1: capture request attributes and the selected word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_tid    <= '0;
         s1_len8   <= 1'b0;
         s1_hi     <= 1'b0;
         s1_is_cnt <= 1'b0;
         s1_word   <= 64'h0;
      end else begin
         s1_valid  <= rx_c0.mmioRdValid;
         s1_tid    <= req_hdr_c.tid;
         s1_len8   <= req_hdr_c.length[0];
         s1_hi     <= req_hdr_c.address[0];
         s1_is_cnt <= is_cnt_c;
         s1_word   <= word_c;
      end
   end

   // Stage 2 data: count value is pre-increment for this response
   always_comb begin
      rsp_word_c = s1_is_cnt ? {48'h0, rd_count} : s1_word;
      rsp_data_c = rsp_word_c;
      if (!s1_len8)
         rsp_data_c = s1_hi ? {32'h0, rsp_word_c[63:32]} : {32'h0, rsp_word_c[31:0]};
   end

   // Stage 2: response register and response counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_c2    <= '0;
         rd_count <= 16'h0;
      end else begin
         tx_c2.mmioRdValid <= s1_valid;
         tx_c2.hdr.tid     <= s1_tid;
         tx_c2.data        <= rsp_data_c;
         rd_count          <= rd_count + 16'(s1_valid);
      end
   end

   // Fields this responder does not consume
   logic unused_c;
   assign unused_c = ^{rx_c0.data, rx_c0.rspValid, rx_c0.mmioWrValid,
                       req_hdr_c.rsvd, req_hdr_c.length[1]};

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Directed self-checking bench for hc_mmio_rd_responder.
module tb_hc_mmio_rd_responder;
   import hc_ccip_pkg::*;

   localparam logic [63:0] ID_L = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] ID_H = 64'hCAFE_F00D_8765_4321;
   localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;

   localparam logic [63:0] BUF0_ADDR = 64'h0000_00AB_CDEF_0000;
   localparam logic [31:0] BUF0_SIZE = 32'h0000_1000;
   localparam logic [63:0] BUF1_ADDR = 64'h0000_0012_3456_7000;
   localparam logic [31:0] BUF1_SIZE = 32'h0000_2000;

   logic            clk = 1'b0;
   logic            reset_n;
   t_if_ccip_c0_Rx  rx_c0;
   t_if_ccip_c2_Tx  tx_c2;
   logic [63:0]     csr_dsm_base;
   logic [31:0]     csr_control;
   logic [191:0]    csr_buffers;
   logic [7:0]      status;
   logic [15:0]     rd_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hc_mmio_rd_responder #(
      .AFU_ID_L    (ID_L),
      .AFU_ID_H    (ID_H),
      .DFH_VALUE   (DFH),
      .BUFFER_SIZE (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_c0        (rx_c0),
      .tx_c2        (tx_c2),
      .csr_dsm_base (csr_dsm_base),
      .csr_control  (csr_control),
      .csr_buffers  (csr_buffers),
      .status       (status),
      .rd_count     (rd_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_rd(input logic [15:0] a, input logic len8, input logic [8:0] tid);
      t_ccip_c0_ReqMmioHdr h;
      h               = '0;
      h.address       = a;
      h.length        = {1'b0, len8};
      h.tid           = tid;
      rx_c0.hdr         = t_ccip_c0_RspMemHdr'(h);
      rx_c0.data        = '1;
      rx_c0.rspValid    = 1'b0;
      rx_c0.mmioRdValid = 1'b1;
      rx_c0.mmioWrValid = 1'b0;
   endtask

   task automatic idle();
      rx_c0 = '0;
   endtask

   task automatic chk_rsp(input string tag, input logic [8:0] tid, input logic [63:0] data);
      chk({tag, "_valid"}, 64'(tx_c2.mmioRdValid), 64'd1);
      chk({tag, "_tid"},   64'(tx_c2.hdr.tid),     64'(tid));
      chk({tag, "_data"},  tx_c2.data,              data);
   endtask

   // One isolated read: silent at T+1, response at T+2, gone at T+3
   task automatic single(input string tag, input logic [15:0] a, input logic len8,
                         input logic [8:0] tid, input logic [63:0] exp);
      drive_rd(a, len8, tid);
      @(negedge clk);
      idle();
      chk({tag, "_early"}, 64'(tx_c2.mmioRdValid), 64'd0);
      @(negedge clk);
      chk_rsp(tag, tid, exp);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(tx_c2.mmioRdValid), 64'd0);
   endtask

   initial begin
      reset_n      = 1'b0;
      idle();
      csr_dsm_base = 64'h1111_2222_3333_4444;
      csr_control  = 32'h1;
      csr_buffers  = {BUF1_ADDR, BUF1_SIZE, BUF0_ADDR, BUF0_SIZE};
      status       = 8'hA5;

      // Reads pulsing while held in reset produce nothing
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) drive_rd(16'h0002, 1'b1, 9'h1A5);
         else            idle();
         @(negedge clk);
         chk("rst_valid", 64'(tx_c2.mmioRdValid), 64'd0);
         chk("rst_cnt",   64'(rd_count),          64'd0);
         chk("rst_data",  tx_c2.data,             64'd0);
      end
      idle();
      reset_n = 1'b1;

      single("id_l", 16'h0002, 1'b1, 9'h1A5, ID_L);
      chk("cnt_after_first", 64'(rd_count), 64'd1);
      single("dsm_lo", 16'h0044, 1'b0, 9'h011, 64'h0000_0000_3333_4444);
      single("dsm_hi", 16'h0045, 1'b0, 9'h012, 64'h0000_0000_1111_2222);
      single("dfh",    16'h0000, 1'b1, 9'h013, DFH);
      single("id_h",   16'h0004, 1'b1, 9'h014, ID_H);
      single("status", 16'h007C, 1'b1, 9'h015, 64'h0000_0000_0000_00A5);
      single("cnt_rd", 16'h007E, 1'b1, 9'h016, 64'd6);
      chk("cnt_after_cnt_rd", 64'(rd_count), 64'd7);
      single("buf_slot2", 16'h0050, 1'b1, 9'h017, 64'd0);
      single("win_0x400", 16'h0100, 1'b1, 9'h018, 64'd0);
      single("dfh_4b_hi", 16'h0001, 1'b0, 9'h019, 64'h0000_0000_1000_0000);
      single("gap_0x018", 16'h0006, 1'b1, 9'h01A, 64'd0);

      // Fresh reset before the burst
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst2_cnt", 64'(rd_count), 64'd0);
      reset_n = 1'b1;

      // Back-to-back burst, then two back-to-back count reads
      drive_rd(16'h0046, 1'b1, 9'd1);
      @(negedge clk);
      drive_rd(16'h0048, 1'b1, 9'd2);
      @(negedge clk);
      drive_rd(16'h004A, 1'b1, 9'd3);
      chk_rsp("burst1", 9'd1, 64'h1);
      @(negedge clk);
      drive_rd(16'h004C, 1'b1, 9'd4);
      chk_rsp("burst2", 9'd2, BUF0_ADDR);
      @(negedge clk);
      drive_rd(16'h007E, 1'b1, 9'd5);
      chk_rsp("burst3", 9'd3, {32'h0, BUF0_SIZE});
      @(negedge clk);
      drive_rd(16'h007E, 1'b1, 9'd6);
      chk_rsp("burst4", 9'd4, BUF1_ADDR);
      chk("burst_cnt", 64'(rd_count), 64'd4);
      @(negedge clk);
      idle();
      chk_rsp("cnt_b2b_a", 9'd5, 64'd4);
      @(negedge clk);
      chk_rsp("cnt_b2b_b", 9'd6, 64'd5);
      chk("cnt_after_b2b", 64'(rd_count), 64'd6);
      @(negedge clk);
      chk("burst_end", 64'(tx_c2.mmioRdValid), 64'd0);

      // Write collides with read of control; control updates at the same edge
      drive_rd(16'h0046, 1'b1, 9'd7);
      rx_c0.mmioWrValid = 1'b1;
      @(posedge clk);
      #1;
      csr_control = 32'h3;
      idle();
      @(negedge clk);
      chk("coll_early", 64'(tx_c2.mmioRdValid), 64'd0);
      @(negedge clk);
      chk_rsp("coll", 9'd7, 64'h1);
      @(negedge clk);
      single("ctl_new", 16'h0046, 1'b1, 9'd8, 64'h3);
      single("unmapped", 16'h00C0, 1'b1, 9'd9, 64'd0);

      // Reset mid-flight discards both outstanding reads
      drive_rd(16'h0000, 1'b1, 9'd10);
      @(negedge clk);
      drive_rd(16'h0000, 1'b1, 9'd11);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_valid", 64'(tx_c2.mmioRdValid), 64'd0);
         chk("mid_rst_cnt",   64'(rd_count),          64'd0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
